instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Pipeline stage 1 of the MIPS core: holds the PC, reads instruction memory, and registers the IF/ID pair (instruction, PC+4) consumed by `instruction_decode`. It accepts taken-branch redirects and the load-use stall from ID, and detects the HALT instruction so the debug unit knows the program has ended. A write port lets the debug/UART loader fill instruction memory before execution.

## Interface
- `NB_DATA`, 32: instruction/PC width
- `NB_IMEM_ADDR`, 8: word-address width; depth = 2**NB_IMEM_ADDR words

- `i_clk` in 1: single clock, all state on rising edge
- `i_reset` in 1: synchronous, active-low reset
- `i_enable` in 1: run/step enable from debug unit; 0 freezes every register in the stage
- `i_stall` in 1: hazard-detector stall; holds PC and IF/ID
- `i_jump` in 1: taken branch from ID (combinational, same cycle)
- `i_jump_addr` in NB_DATA: branch target from ID
- `i_imem_wr_en` in 1: loader write strobe
- `i_imem_wr_addr` in NB_IMEM_ADDR: loader word address
- `i_imem_wr_data` in NB_DATA: loader word
- `o_instruction` out NB_DATA: IF/ID instruction
- `o_pc4` out NB_DATA: IF/ID PC+4 of that instruction
- `o_pc` out NB_DATA: current PC (debug readout)
- `o_halt` out 1: stage is in HALTED

## Operation
- Fetch word = imem[pc[NB_IMEM_ADDR+1:2]], asynchronous read; index wraps modulo depth; PC arithmetic is 32-bit unsigned, wraps at 2**32.
- FSM states RUN, HALTED. Priority per edge: reset > `i_enable`=0 > `i_stall` > `i_jump` > normal/halt.
- Reset (`i_reset`=0): pc=0, o_instruction=0 (NOP), o_pc4=0, o_halt=0, state RUN. Memory contents not cleared.
- `i_enable`=0: pc, IF/ID, state held. Loader writes still occur.
- `i_stall`=1: pc and IF/ID held; a coincident `i_jump` is ignored (ID re-evaluates after the stall).
- RUN, `i_jump`=1: pc <= {i_jump_addr[31:2],2'b00}; IF/ID <= NOP, o_pc4 <= 0 (flush; no delay slot). A fetched HALT in that cycle is squashed; state stays RUN.
- RUN, normal: IF/ID <= {fetch word, pc+4}; pc <= pc+4.
- RUN, fetch word == HALT (32'hFFFF_FFFF): IF/ID <= {HALT, pc+4}; pc held; state -> HALTED.
- HALTED: pc held; IF/ID <= NOP on each enabled, unstalled cycle; `i_jump` ignored; exit only via reset.
- Loader write: imem[wr_addr] <= wr_data on edge when `i_imem_wr_en`=1, regardless of state/enable/reset. Same-cycle read of that address returns the old word.

## Timing
- PC -> o_instruction latency: 1 cycle.
- `i_jump` at edge N: target instruction appears on o_instruction after edge N+1; exactly one NOP bubble.
- `o_halt` asserts the cycle after the HALT edge, same cycle HALT is on o_instruction.
- Stall of k cycles delays the stream by exactly k cycles; no instruction lost or duplicated.
- o_pc = pc register, o_halt = (state==HALTED), both registered.

## Structure
- Shared package `mips_pkg`: HALT_INSTR=32'hFFFF_FFFF, NOP_INSTR=32'h0, NB_DATA, FSM state encoding (RUN, HALTED).
- Sub-module `instruction_memory`: async read port, sync write port, parameter NB_IMEM_ADDR.
- Top holds PC, FSM, IF/ID registers and next-PC mux.

## Test plan
- Load imem[0..3]={A,B,C,HALT}, reset, enable -> o_instruction A,B,C,HALT on consecutive cycles, o_pc4 4,8,12,16; o_halt=1 with HALT; then NOP, o_pc stays 12.
- i_jump=1, i_jump_addr=0x40 while pc=0x8 -> next o_instruction NOP/o_pc4=0, following cycle imem[16] with o_pc4=0x44.
- i_stall=1 for 3 cycles with i_jump=1 at stall cycle 2 -> pc and IF/ID frozen, jump ignored, stream resumes with next sequential word.
- i_enable=0 mid-program for 5 cycles, loader writes word at pc index -> outputs frozen; on re-enable the new word is fetched.
- HALT at pc=8 coincident with i_jump to 0x20 -> no halt, o_halt=0, imem[8] fetched next.
- i_reset=0 while HALTED -> next cycle pc=0, o_halt=0, o_instruction=0; memory retains program and reruns from word 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Constants shared by the MIPS pipeline stages: special instruction words,
// datapath width and the fetch-stage FSM encoding.
package mips_pkg;

  localparam int NB_DATA = 32;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction memory: combinational read for fetch, synchronous
// write port for the debug/UART program loader.
module instruction_memory #(
  parameter int NB_DATA      = mips_pkg::NB_DATA,
  parameter int NB_IMEM_ADDR = 8
) (
  input  logic                    i_clk,
  input  logic                    i_wr_en,
  input  logic [NB_IMEM_ADDR-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0]      i_wr_data,
  input  logic [NB_IMEM_ADDR-1:0] i_rd_addr,
  output logic [NB_DATA-1:0]      o_rd_data
);

  logic [NB_DATA-1:0] r_mem [2**NB_IMEM_ADDR];

  // The loader owns this port outright: no reset or enable gating.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, next-PC selection, IF/ID pipeline register and the
// RUN/HALTED state that tells the debug unit the program has finished.
module instruction_fetch #(
  parameter int NB_DATA      = mips_pkg::NB_DATA,
  parameter int NB_IMEM_ADDR = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_stall,
  input  logic                    i_jump,
  input  logic [NB_DATA-1:0]      i_jump_addr,
  input  logic                    i_imem_wr_en,
  input  logic [NB_IMEM_ADDR-1:0] i_imem_wr_addr,
  input  logic [NB_DATA-1:0]      i_imem_wr_data,
  output logic [NB_DATA-1:0]      o_instruction,
  output logic [NB_DATA-1:0]      o_pc4,
  output logic [NB_DATA-1:0]      o_pc,
  output logic                    o_halt
);

  logic [NB_DATA-1:0] r_pc;
  logic [NB_DATA-1:0] r_instruction;
  logic [NB_DATA-1:0] r_pc4;
  logic [0:0]         r_state;

  logic [NB_DATA-1:0] w_fetch;
  logic [NB_DATA-1:0] w_pc_plus4;
  logic [NB_DATA-1:0] w_jump_target;
  logic [1:0]         w_unused_jaddr;

  instruction_memory #(
    .NB_DATA      (NB_DATA),
    .NB_IMEM_ADDR (NB_IMEM_ADDR)
  ) u_imem (
    .i_clk     (i_clk),
    .i_wr_en   (i_imem_wr_en),
    .i_wr_addr (i_imem_wr_addr),
    .i_wr_data (i_imem_wr_data),
    .i_rd_addr (r_pc[NB_IMEM_ADDR+1:2]),
    .o_rd_data (w_fetch)
  );

  assign w_pc_plus4     = r_pc + NB_DATA'(4);
  assign w_jump_target  = {i_jump_addr[NB_DATA-1:2], 2'b00};
  assign w_unused_jaddr = i_jump_addr[1:0];

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_pc          <= '0;
      r_instruction <= NB_DATA'(mips_pkg::NOP_INSTR);
      r_pc4         <= '0;
      r_state       <= mips_pkg::ST_RUN;
    end else if (i_enable && !i_stall) begin
      if (r_state == mips_pkg::ST_HALTED) begin
        // Parked: keep feeding bubbles downstream until the next reset.
        r_instruction <= NB_DATA'(mips_pkg::NOP_INSTR);
        r_pc4         <= '0;
      end else if (i_jump) begin
        // Flush the wrong-path word; a HALT fetched here is discarded too.
        r_pc          <= w_jump_target;
        r_instruction <= NB_DATA'(mips_pkg::NOP_INSTR);
        r_pc4         <= '0;
      end else if (w_fetch == NB_DATA'(mips_pkg::HALT_INSTR)) begin
        r_instruction <= w_fetch;
        r_pc4         <= w_pc_plus4;
        r_state       <= mips_pkg::ST_HALTED;
      end else begin
        r_pc          <= w_pc_plus4;
        r_instruction <= w_fetch;
        r_pc4         <= w_pc_plus4;
      end
    end
  end

  assign o_instruction = r_instruction;
  assign o_pc4         = r_pc4;
  assign o_pc          = r_pc;
  assign o_halt        = (r_state == mips_pkg::ST_HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed scoreboard bench for instruction_fetch: each stimulus step queues
// the expected post-edge outputs, and a negedge monitor pops and compares them.
module tb_instruction_fetch;

  localparam logic [31:0] WA   = 32'h1111_1111;
  localparam logic [31:0] WB   = 32'h2222_2222;
  localparam logic [31:0] WC   = 32'h3333_3333;
  localparam logic [31:0] HLT  = 32'hFFFF_FFFF;
  localparam logic [31:0] W8   = 32'h0808_0808;
  localparam logic [31:0] W9   = 32'h0909_0909;
  localparam logic [31:0] W16  = 32'h1616_1616;
  localparam logic [31:0] W17  = 32'h1717_1717;
  localparam logic [31:0] W18  = 32'h1818_1818;
  localparam logic [31:0] W19  = 32'h1919_1919;
  localparam logic [31:0] W20N = 32'h2020_ABCD;
  localparam logic [31:0] W21O = 32'h2121_0000;
  localparam logic [31:0] W21N = 32'h2121_FFFE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] instruction, pc4, pc;
  logic        halt;

  int cyc_cnt = 0;
  int n_checks = 0;
  int n_fails = 0;

  typedef struct {
    int          cyc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] pc;
    logic        halt;
    bit          chk_pc4;
  } exp_t;

  exp_t sb[$];

  instruction_fetch #(.NB_DATA(32), .NB_IMEM_ADDR(8)) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_enable       (enable),
    .i_stall        (stall),
    .i_jump         (jump),
    .i_jump_addr    (jump_addr),
    .i_imem_wr_en   (wr_en),
    .i_imem_wr_addr (wr_addr),
    .i_imem_wr_data (wr_data),
    .o_instruction  (instruction),
    .o_pc4          (pc4),
    .o_pc           (pc),
    .o_halt         (halt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc_cnt, act, req);
    end
  endtask

  // Monitor: compares whenever the DUT has produced the output a step predicted.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      if (sb[0].cyc == cyc_cnt) begin
        exp_t e;
        e = sb.pop_front();
        $display("txn cyc=%0d instr=%h pc4=%h pc=%h halt=%0b", cyc_cnt, instruction, pc4, pc, halt);
        chk("instr", instruction, e.instr);
        if (e.chk_pc4) chk("pc4", pc4, e.pc4);
        chk("pc", pc, e.pc);
        chk("halt", {31'b0, halt}, {31'b0, e.halt});
      end else if (sb[0].cyc < cyc_cnt) begin
        void'(sb.pop_front());
        n_checks++;
        n_fails++;
        $display("FAIL missed_txn cyc=%0d got=none want=one", cyc_cnt);
      end
    end
  end

  task automatic step(input logic r, input logic en, input logic st, input logic jp,
                      input logic [31:0] ja, input logic we, input logic [7:0] wa,
                      input logic [31:0] wd, input logic [31:0] e_instr,
                      input logic [31:0] e_pc4, input logic [31:0] e_pc,
                      input logic e_halt, input bit e_chk4);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; enable = en; stall = st; jump = jp; jump_addr = ja;
    wr_en = we; wr_addr = wa; wr_data = wd;
    e.cyc = cyc_cnt + 1;
    e.instr = e_instr; e.pc4 = e_pc4; e.pc = e_pc; e.halt = e_halt; e.chk_pc4 = e_chk4;
    sb.push_back(e);
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, a, d, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic run(input logic st, input logic jp, input logic [31:0] ja,
                     input logic [31:0] e_instr, input logic [31:0] e_pc4,
                     input logic [31:0] e_pc, input logic e_halt);
    step(1'b1, 1'b1, st, jp, ja, 1'b0, '0, '0, e_instr, e_pc4, e_pc, e_halt, 1'b1);
  endtask

  task automatic halted_nop(input logic jp, input logic [31:0] ja, input logic [31:0] e_pc);
    step(1'b1, 1'b1, 1'b0, jp, ja, 1'b0, '0, '0, 32'h0, 32'h0, e_pc, 1'b1, 1'b0);
  endtask

  initial begin
    // Program load under reset; outputs must sit at the reset values.
    load(8'd0, WA);  load(8'd1, WB);  load(8'd2, WC);  load(8'd3, HLT);
    load(8'd8, W8);  load(8'd9, W9);
    load(8'd16, W16); load(8'd17, W17); load(8'd18, W18); load(8'd19, W19);
    load(8'd21, W21O);

    // Straight-line run into HALT.
    run(1'b0, 1'b0, '0, WA, 32'd4, 32'd4, 1'b0);
    run(1'b0, 1'b0, '0, WB, 32'd8, 32'd8, 1'b0);
    run(1'b0, 1'b0, '0, WC, 32'd12, 32'd12, 1'b0);
    run(1'b0, 1'b0, '0, HLT, 32'd16, 32'd12, 1'b1);
    halted_nop(1'b0, '0, 32'd12);
    halted_nop(1'b1, 32'h0, 32'd12);

    // Reset out of HALTED, program reruns; taken jump from pc=8.
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    run(1'b0, 1'b0, '0, WA, 32'd4, 32'd4, 1'b0);
    run(1'b0, 1'b0, '0, WB, 32'd8, 32'd8, 1'b0);
    run(1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 32'h40, 1'b0);
    run(1'b0, 1'b0, '0, W16, 32'h44, 32'h44, 1'b0);
    run(1'b0, 1'b0, '0, W17, 32'h48, 32'h48, 1'b0);

    // Three-cycle stall, jump in the middle one is ignored.
    run(1'b1, 1'b0, '0, W17, 32'h48, 32'h48, 1'b0);
    run(1'b1, 1'b1, 32'h0, W17, 32'h48, 32'h48, 1'b0);
    run(1'b1, 1'b0, '0, W17, 32'h48, 32'h48, 1'b0);
    run(1'b0, 1'b0, '0, W18, 32'h4C, 32'h4C, 1'b0);
    run(1'b0, 1'b0, '0, W19, 32'h50, 32'h50, 1'b0);

    // Disabled for five cycles while the loader patches the word at pc.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, (i == 1), 8'd20, W20N,
           W19, 32'h50, 32'h50, 1'b0, 1'b1);
    end
    run(1'b0, 1'b0, '0, W20N, 32'h54, 32'h54, 1'b0);

    // Write to the word being fetched: old word this edge, new word after.
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1, 8'd21, W21N, W21O, 32'h58, 32'h58, 1'b0, 1'b1);
    run(1'b0, 1'b1, 32'h57, 32'h0, 32'h0, 32'h54, 1'b0);
    run(1'b0, 1'b0, '0, W21N, 32'h58, 32'h58, 1'b0);

    // HALT at pc=8 squashed by a coincident jump to 0x20.
    load(8'd2, HLT);
    run(1'b0, 1'b0, '0, WA, 32'd4, 32'd4, 1'b0);
    run(1'b0, 1'b0, '0, WB, 32'd8, 32'd8, 1'b0);
    run(1'b0, 1'b1, 32'h20, 32'h0, 32'h0, 32'h20, 1'b0);
    run(1'b0, 1'b0, '0, W8, 32'h24, 32'h24, 1'b0);
    run(1'b0, 1'b0, '0, W9, 32'h28, 32'h28, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("FAIL sb_drain got=%0d want=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
